param_fifo: RTL and testbench

- Fully RTL, parametrised synchronous FIFO; next generation of the minilab FIFO and the replacement for the vendor-IP-based FIFO wrapper.
- Generalised width and depth; simultaneous read/write in the same cycle.
- Adds a fill count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous clear, and a selectable normal or show-ahead (first-word-fall-through) read mode.
- Sits between producer and consumer datapaths (e.g. matrix/vector operand buffering).

---
 rtl/param_fifo.sv | 117 +++++++++++
 tb/tb_param_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with fill count, threshold flags, sticky error flags,
// synchronous clear and a selectable registered or show-ahead read port.
module param_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int SHOW_AHEAD = 0,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wren,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       rden,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags decode from the count register alone, so they follow the accepting edge.
    assign full         = (count_reg == DEPTH_C);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_C);
    assign almost_empty = (count_reg <= AE_C);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    assign wr_acc = wren && !full;
    assign rd_acc = rden && !empty;

    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clr) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_acc) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            if (wren && full)  overflow_reg  <= 1'b1;
            if (rden && empty) underflow_reg <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset so it maps onto RAM resources.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr) mem[wr_ptr_reg] <= i_data;
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            assign o_data  = mem[rd_ptr_reg];
            assign o_valid = !empty;
        end else begin : g_normal
            logic [DATA_WIDTH-1:0] o_data_reg;
            logic                  o_valid_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_data_reg  <= '0;
                    o_valid_reg <= 1'b0;
                end else if (clr) begin
                    o_data_reg  <= '0;
                    o_valid_reg <= 1'b0;
                end else begin
                    o_valid_reg <= rd_acc;
                    if (rd_acc) o_data_reg <= mem[rd_ptr_reg];
                end
            end

            assign o_data  = o_data_reg;
            assign o_valid = o_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Drives three FIFO variants (normal, show-ahead, custom thresholds) with shared stimulus
// and compares every output against a queue-based reference after each edge.
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr = 1'b0;
    logic       wren = 1'b0;
    logic       rden = 1'b0;
    logic [7:0] i_data = 8'h00;

    logic [7:0] n_data, s_data, t_data;
    logic       n_valid, s_valid, t_valid;
    logic [3:0] n_count, s_count, t_count;
    logic       n_full, s_full, t_full;
    logic       n_empty, s_empty, t_empty;
    logic       n_af, s_af, t_af;
    logic       n_ae, s_ae, t_ae;
    logic       n_ovf, s_ovf, t_ovf;
    logic       n_udf, s_udf, t_udf;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         m_ovf, m_udf, m_nvalid;
    logic [7:0] m_ndata;

    always #5 clk = ~clk;

    param_fifo #(.DATA_WIDTH(8), .DEPTH(8), .SHOW_AHEAD(0)) u_norm (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .i_data(i_data), .rden(rden),
        .o_data(n_data), .o_valid(n_valid), .count(n_count), .full(n_full), .empty(n_empty),
        .almost_full(n_af), .almost_empty(n_ae), .overflow(n_ovf), .underflow(n_udf));

    param_fifo #(.DATA_WIDTH(8), .DEPTH(8), .SHOW_AHEAD(1)) u_sa (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .i_data(i_data), .rden(rden),
        .o_data(s_data), .o_valid(s_valid), .count(s_count), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_udf));

    param_fifo #(.DATA_WIDTH(8), .DEPTH(8), .SHOW_AHEAD(0), .AF_THRESH(6), .AE_THRESH(2)) u_thr (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .i_data(i_data), .rden(rden),
        .o_data(t_data), .o_valid(t_valid), .count(t_count), .full(t_full), .empty(t_empty),
        .almost_full(t_af), .almost_empty(t_ae), .overflow(t_ovf), .underflow(t_udf));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_udf = 0;
        m_nvalid = 0;
        m_ndata = 8'h00;
    endtask

    // Applies the acceptance rules to the state that existed before the edge.
    task automatic model_edge();
        int sz = q.size();
        bit was_full = (sz == 8);
        bit was_empty = (sz == 0);
        if (clr) begin
            model_reset();
        end else begin
            if (wren && was_full) m_ovf = 1;
            if (rden && was_empty) m_udf = 1;
            m_nvalid = rden && !was_empty;
            if (m_nvalid) m_ndata = q.pop_front();
            if (wren && !was_full) q.push_back(i_data);
        end
    endtask

    task automatic check_all(input string tag, input bit quiet);
        int sz = q.size();
        check({tag, " n.count"}, int'(n_count), sz);
        check({tag, " n.full"}, int'(n_full), int'(sz == 8));
        check({tag, " n.empty"}, int'(n_empty), int'(sz == 0));
        check({tag, " n.af"}, int'(n_af), int'(sz >= 7));
        check({tag, " n.ae"}, int'(n_ae), int'(sz <= 1));
        check({tag, " n.ovf"}, int'(n_ovf), int'(m_ovf));
        check({tag, " n.udf"}, int'(n_udf), int'(m_udf));
        check({tag, " n.valid"}, int'(n_valid), int'(m_nvalid));
        check({tag, " n.data"}, int'(n_data), int'(m_ndata));
        check({tag, " s.count"}, int'(s_count), sz);
        check({tag, " s.valid"}, int'(s_valid), int'(sz != 0));
        if (sz != 0) check({tag, " s.data"}, int'(s_data), int'(q[0]));
        check({tag, " s.ovf"}, int'(s_ovf), int'(m_ovf));
        check({tag, " s.udf"}, int'(s_udf), int'(m_udf));
        check({tag, " t.af"}, int'(t_af), int'(sz >= 6));
        check({tag, " t.ae"}, int'(t_ae), int'(sz <= 2));
        check({tag, " t.count"}, int'(t_count), sz);
        if (!quiet)
            $display("%s: w=%0b r=%0b c=%0b d=%02h -> count=%0d n_out=%02h/%0b s_out=%02h/%0b ovf=%0b udf=%0b",
                     tag, wren, rden, clr, i_data, n_count, n_data, n_valid, s_data, s_valid, n_ovf, n_udf);
    endtask

    task automatic cycle(input string tag, input bit w, input bit r, input logic [7:0] d, input bit c,
                         input bit quiet = 0);
        wren = w;
        rden = r;
        i_data = d;
        clr = c;
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag, quiet);
    endtask

    // Called mid-cycle; reset stays low across one edge and releases mid-cycle.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, " async"}, 0);
        @(posedge clk);
        #1;
        check_all({tag, " held"}, 0);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        apply_reset("reset");

        for (int i = 0; i < 8; i++) cycle("fill", 1, 0, 8'(8'h10 + i), 0);
        cycle("overflow", 1, 0, 8'hAA, 0);
        for (int i = 0; i < 8; i++) cycle("drain", 0, 1, 8'h00, 0);
        cycle("idle", 0, 0, 8'h00, 0);
        cycle("underflow", 0, 1, 8'h00, 0);
        cycle("clr", 0, 0, 8'h00, 1);
        cycle("clr_req", 1, 1, 8'h33, 1);

        for (int i = 0; i < 3; i++) cycle("pre3", 1, 0, 8'(8'h20 + i), 0);
        for (int i = 0; i < 20; i++) cycle("rw3", 1, 1, 8'(8'h30 + i), 0);
        for (int i = 0; i < 3; i++) cycle("drain3", 0, 1, 8'h00, 0);
        cycle("rw_empty", 1, 1, 8'h44, 0);
        for (int i = 0; i < 7; i++) cycle("fill8", 1, 0, 8'(8'h50 + i), 0);
        cycle("rw_full", 1, 1, 8'h66, 0);
        cycle("clr2", 0, 0, 8'h00, 1);

        cycle("sa_w5a", 1, 0, 8'h5A, 0);
        cycle("sa_idle", 0, 0, 8'h00, 0);
        cycle("sa_w5b", 1, 0, 8'h5B, 0);
        cycle("sa_pop", 0, 1, 8'h00, 0);
        cycle("sa_pop2", 0, 1, 8'h00, 0);

        for (int i = 0; i < 8; i++) cycle("thr_up", 1, 0, 8'(8'h80 + i), 0);
        for (int i = 0; i < 8; i++) cycle("thr_dn", 0, 1, 8'h00, 0);

        for (int i = 0; i < 5; i++) cycle("pre5", 1, 0, 8'(8'h90 + i), 0);
        cycle("rw5", 1, 1, 8'h95, 0);
        #2;
        apply_reset("midreset");
        cycle("post_rst", 0, 0, 8'h00, 0);
        cycle("post_w", 1, 0, 8'h77, 0);
        cycle("post_r", 0, 1, 8'h00, 0);
        cycle("post_idle", 0, 0, 8'h00, 0);

        for (int ph = 0; ph < 8; ph++) begin
            int wp = (ph % 2 == 0) ? 75 : 30;
            for (int i = 0; i < 300; i++) begin
                bit w = ($urandom_range(0, 99) < wp);
                bit r = ($urandom_range(0, 99) < (100 - wp));
                bit c = ($urandom_range(0, 127) == 0);
                cycle("rand", w, r, 8'($urandom), c, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
